// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache: geometry constants, the
// fill FSM state type and a block-to-word selection helper.
package icache_pkg;

  localparam int unsigned BLOCK_W    = 128;  // one memory block / cache line
  localparam int unsigned WORD_W     = 32;   // one instruction
  localparam int unsigned OFFSET_W   = 2;    // word select within a block
  localparam int unsigned MEM_ADDR_W = 28;   // block address (PC[31:4])

  typedef enum logic [1:0] {
    StIdle,
    StMemRead,
    StUpdate
  } icache_state_e;

  // Word n of a block occupies bits [32n+31:32n].
  function automatic logic [WORD_W-1:0] select_word(input logic [BLOCK_W-1:0]  block,
                                                    input logic [OFFSET_W-1:0] offset);
    return block[WORD_W*offset +: WORD_W];
  endfunction

endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage for the direct-mapped instruction cache.
// Ports:
//   clock, reset          - clock; synchronous active-high clear of all valid bits
//   rd_index              - combinational read port index
//   rd_valid/tag/data     - contents of the indexed line
//   wr_en, wr_index       - synchronous line fill strobe and target line
//   wr_tag, wr_data       - tag and block written on a fill (valid is set)
module icache_line_array
  import icache_pkg::*;
#(
  parameter int unsigned LINES   = 8,
  parameter int unsigned INDEX_W = $clog2(LINES),
  parameter int unsigned TAG_W   = MEM_ADDR_W - INDEX_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [INDEX_W-1:0] rd_index,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [BLOCK_W-1:0] rd_data,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [BLOCK_W-1:0] wr_data
);

  logic [LINES-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [BLOCK_W-1:0] data_q [LINES];

  // Reset wins over a fill landing on the same edge, so an interrupted
  // fill never leaves a valid line behind.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // Tag and data need no reset: they are only observed through valid.
  always_ff @(posedge clock) begin
    if (wr_en && !reset) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped, read-only instruction cache between the fetch stage and a
// 128-bit block instruction memory. Hits return the word in the same cycle;
// a miss stalls the CPU, fetches the block, fills the line and replays.
// Ports:
//   clock, reset         - clock; synchronous active-high reset
//   read, address        - CPU fetch request and byte PC (bits [1:0] ignored)
//   instruction          - selected word of the indexed line (always driven)
//   busywait             - CPU stall
//   mem_read/mem_address - block read request and latched block address
//   mem_readdata         - returned block, byte 0 in bits [7:0]
//   mem_busywait         - memory busy
//   hit_count/miss_count - performance counters, only with ICACHE_PERF_EN defined
module instruction_cache
  import icache_pkg::*;
#(
  parameter int unsigned LINES = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  read,
  input  logic [31:0]           address,
  output logic [WORD_W-1:0]     instruction,
  output logic                  busywait,
  output logic                  mem_read,
  output logic [MEM_ADDR_W-1:0] mem_address,
  input  logic [BLOCK_W-1:0]    mem_readdata,
  input  logic                  mem_busywait
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);

  localparam int unsigned INDEX_W = $clog2(LINES);
  localparam int unsigned TAG_W   = MEM_ADDR_W - INDEX_W;

  icache_state_e         state_q, state_d;
  logic                  first_q, first_d;  // in first MEM_READ cycle
  logic [MEM_ADDR_W-1:0] miss_addr_q, miss_addr_d;
  logic [BLOCK_W-1:0]    fill_data_q, fill_data_d;

  logic [OFFSET_W-1:0]   offset;
  logic [INDEX_W-1:0]    index;
  logic [TAG_W-1:0]      tag;
  logic                  line_valid;
  logic [TAG_W-1:0]      line_tag;
  logic [BLOCK_W-1:0]    line_data;
  logic                  line_we;
  logic                  hit;
  logic                  unused_addr;

  assign offset      = address[3:2];
  assign index       = address[4 +: INDEX_W];
  assign tag         = address[31 -: TAG_W];
  assign unused_addr = ^address[1:0];

  icache_line_array #(
    .LINES   (LINES),
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_lines (
    .clock    (clock),
    .reset    (reset),
    .rd_index (index),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .wr_en    (line_we),
    .wr_index (miss_addr_q[INDEX_W-1:0]),
    .wr_tag   (miss_addr_q[MEM_ADDR_W-1 -: TAG_W]),
    .wr_data  (fill_data_q)
  );

  assign hit         = read && line_valid && (line_tag == tag);
  assign instruction = select_word(line_data, offset);
  assign mem_address = miss_addr_q;

  always_comb begin
    state_d     = state_q;
    first_d     = 1'b0;
    miss_addr_d = miss_addr_q;
    fill_data_d = fill_data_q;
    busywait    = 1'b0;
    mem_read    = 1'b0;
    line_we     = 1'b0;
    unique case (state_q)
      StIdle: begin
        busywait = read && !hit;
        if (read && !hit) begin
          state_d     = StMemRead;
          first_d     = 1'b1;
          miss_addr_d = address[31:4];
        end
      end
      StMemRead: begin
        busywait = 1'b1;
        mem_read = 1'b1;
        // A low mem_busywait in the first cycle may be stale from before the
        // memory saw the request, so it is not trusted.
        if (!first_q && !mem_busywait) begin
          state_d     = StUpdate;
          fill_data_d = mem_readdata;
        end
      end
      StUpdate: begin
        busywait = 1'b1;
        line_we  = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      first_q     <= 1'b0;
      miss_addr_q <= '0;
      fill_data_q <= '0;
    end else begin
      state_q     <= state_d;
      first_q     <= first_d;
      miss_addr_q <= miss_addr_d;
      fill_data_q <= fill_data_d;
    end
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_count_q, miss_count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else if (state_q == StIdle) begin
      if (hit && (hit_count_q != '1)) begin
        hit_count_q <= hit_count_q + 32'd1;
      end
      if (read && !hit && (miss_count_q != '1)) begin
        miss_count_q <= miss_count_q + 32'd1;
      end
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule
